// File: rtl/csh_lookup_seq.sv
// csh_lookup_seq: cache-directory lookup sequencer with per-set tree pseudo-LRU victim selection
module csh_lookup_seq #(
    parameter int SETS    = 128,
    parameter int IDX_W   = 7,
    parameter int DIR_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic             flush,
    output logic             dir_lookup,
    output logic [IDX_W-1:0] dir_idx,
    input  logic [3:0]       VALID_MATCH,
    input  logic             ADR_PAR_BAD,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [1:0]       rsp_way,
    output logic             rsp_err
);
    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   hit_q, hit_d, err_q, err_d;
    logic [1:0]             way_q, way_d;
    logic [SETS-1:0][2:0]   lru_q, lru_d;
    logic [2:0]             lru_cur, lru_touch, pop;
    logic [1:0]             victim, match_way;
    logic                   sample, retire;

    // all state; reset drops any in-flight lookup and clears the LRU array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            way_q   <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
            way_q   <= way_d;
            lru_q   <= lru_d;
        end
    end

    // next state: flush in IDLE wins over a request; WAIT ends when the count reaches 1
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (!flush && req_valid) ? LOOKUP : IDLE;
            LOOKUP:  state_d = WAIT;
            WAIT:    state_d = (cnt_q == 3'd1) ? RESP : WAIT;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // verdict, victim choice and LRU update; the touched way is the hit way or the refilled victim
    always_comb begin
        sample    = (state_q == WAIT) && (cnt_q == 3'd1);
        retire    = (state_q == RESP) && rsp_ready;
        lru_cur   = lru_q[idx_q];
        pop       = 3'(VALID_MATCH[0]) + 3'(VALID_MATCH[1]) + 3'(VALID_MATCH[2]) + 3'(VALID_MATCH[3]);
        match_way = VALID_MATCH[3] ? 2'd3 : VALID_MATCH[2] ? 2'd2 : VALID_MATCH[1] ? 2'd1 : 2'd0;
        victim    = lru_cur[0] ? (lru_cur[2] ? 2'd3 : 2'd2) : (lru_cur[1] ? 2'd1 : 2'd0);
        lru_touch = way_q[1] ? {~way_q[0], lru_cur[1], 1'b0} : {lru_cur[2], ~way_q[0], 1'b1};
        idx_d     = (state_q == IDLE && !flush && req_valid) ? req_idx : idx_q;
        cnt_d     = (state_q == LOOKUP) ? 3'(DIR_LAT) : (state_q == WAIT) ? cnt_q - 3'd1 : cnt_q;
        err_d     = sample ? (ADR_PAR_BAD || pop > 3'd1) : err_q;
        hit_d     = sample ? (!ADR_PAR_BAD && pop == 3'd1) : hit_q;
        way_d     = sample ? ((!ADR_PAR_BAD && pop == 3'd1) ? match_way : victim) : way_q;
        lru_d     = lru_q;
        if (state_q == IDLE && flush)
            lru_d = '0;
        else if (retire && !err_q)
            lru_d[idx_q] = lru_touch;
    end

    // outputs decoded from state and the captured verdict
    always_comb begin
        req_ready  = (state_q == IDLE) && !flush;
        dir_lookup = (state_q == LOOKUP);
        dir_idx    = (state_q == LOOKUP) ? idx_q : '0;
        rsp_valid  = (state_q == RESP);
        rsp_hit    = hit_q;
        rsp_way    = way_q;
        rsp_err    = err_q;
    end
endmodule

// File: tb/tb_csh_lookup_seq.sv
// tb_csh_lookup_seq: directed and random lookups on DIR_LAT=1 and DIR_LAT=4 instances against a pLRU model
module tb_csh_lookup_seq;
    logic       clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0, par = 1'b0, sel = 1'b0;
    logic [6:0] req_idx = '0;
    logic [3:0] vm = '0;
    logic       rr1, dl1, rv1, rh1, re1, rr4, dl4, rv4, rh4, re4;
    logic [6:0] di1, di4;
    logic [1:0] rw1, rw4;
    logic       o_rr, o_dl, o_rv, o_rh, o_re;
    logic [6:0] o_di;
    logic [1:0] o_rw;
    int         checks = 0, fails = 0;
    int         lru_m[2][128];

    always #5 clk = ~clk;

    csh_lookup_seq #(.SETS(128), .IDX_W(7), .DIR_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & !sel), .req_ready(rr1), .req_idx(req_idx),
        .flush(flush), .dir_lookup(dl1), .dir_idx(di1), .VALID_MATCH(vm), .ADR_PAR_BAD(par),
        .rsp_valid(rv1), .rsp_ready(rsp_ready & !sel), .rsp_hit(rh1), .rsp_way(rw1), .rsp_err(re1));

    csh_lookup_seq #(.SETS(128), .IDX_W(7), .DIR_LAT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rr4), .req_idx(req_idx),
        .flush(flush), .dir_lookup(dl4), .dir_idx(di4), .VALID_MATCH(vm), .ADR_PAR_BAD(par),
        .rsp_valid(rv4), .rsp_ready(rsp_ready & sel), .rsp_hit(rh4), .rsp_way(rw4), .rsp_err(re4));

    assign o_rr = sel ? rr4 : rr1;
    assign o_dl = sel ? dl4 : dl1;
    assign o_di = sel ? di4 : di1;
    assign o_rv = sel ? rv4 : rv1;
    assign o_rh = sel ? rh4 : rh1;
    assign o_rw = sel ? rw4 : rw1;
    assign o_re = sel ? re4 : re1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // tree pLRU: bit0 says the LRU half is ways 2/3, bit1 picks within 0/1, bit2 within 2/3
    function automatic int vic(input int b);
        if ((b & 1) != 0) return ((b & 4) != 0) ? 3 : 2;
        return ((b & 2) != 0) ? 1 : 0;
    endfunction

    function automatic int touch(input int b, input int w);
        if (w < 2) return (b & 4) | ((w == 0) ? 2 : 0) | 1;
        return (b & 2) | ((w == 2) ? 4 : 0);
    endfunction

    task automatic clear_model(input int s);
        for (int i = 0; i < 128; i++) lru_m[s][i] = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int idx, input logic [3:0] m, input logic p, input int hold, input int abort);
        int lat, s, pc, exp_hit, exp_err, exp_way;
        lat = sel ? 4 : 1;
        s = sel ? 1 : 0;
        req_valid = 1'b1; req_idx = 7'(idx); vm = 4'($urandom); par = 1'($urandom); #1;
        chk("req_ready_idle", 8'(o_rr), 8'd1);
        cyc();
        req_valid = 1'b0; req_idx = 7'($urandom); vm = 4'($urandom); par = 1'($urandom); #1;
        chk("dir_lookup", 8'(o_dl), 8'd1);
        chk("dir_idx", 8'(o_di), 8'(idx));
        chk("req_ready_busy", 8'(o_rr), 8'd0);
        for (int k = 1; k <= lat; k++) begin
            cyc();
            if (k == lat) begin vm = m; par = p; end
            else begin vm = 4'($urandom); par = 1'($urandom); end
            #1;
            if (k == abort) begin
                rst_n = 1'b0; #1;
                chk("abort_rsp_valid", 8'(o_rv), 8'd0);
                chk("abort_req_ready", 8'(o_rr), 8'd1);
                chk("abort_dir_lookup", 8'(o_dl), 8'd0);
                clear_model(0); clear_model(1);
                #1 rst_n = 1'b1; vm = '0; par = 1'b0;
                for (int c = 0; c < 6; c++) begin
                    cyc();
                    chk("abort_no_rsp", 8'(o_rv), 8'd0);
                end
                return;
            end
            chk("wait_rsp_valid", 8'(o_rv), 8'd0);
            chk("wait_dir_lookup", 8'(o_dl), 8'd0);
        end
        pc = $countones(m);
        exp_err = (p || pc > 1) ? 1 : 0;
        exp_hit = (!p && pc == 1) ? 1 : 0;
        exp_way = vic(lru_m[s][idx]);
        if (exp_hit == 1) for (int w = 0; w < 4; w++) if (m[w]) exp_way = w;
        cyc();
        vm = 4'($urandom); par = 1'($urandom); #1;
        chk("rsp_valid", 8'(o_rv), 8'd1);
        chk("rsp_hit", 8'(o_rh), 8'(exp_hit));
        chk("rsp_way", 8'(o_rw), 8'(exp_way));
        chk("rsp_err", 8'(o_re), 8'(exp_err));
        for (int h = 0; h < hold; h++) begin
            flush = 1'($urandom); #1;
            chk("hold_valid", 8'(o_rv), 8'd1);
            chk("hold_hit", 8'(o_rh), 8'(exp_hit));
            chk("hold_way", 8'(o_rw), 8'(exp_way));
            chk("hold_err", 8'(o_re), 8'(exp_err));
            chk("hold_req_ready", 8'(o_rr), 8'd0);
            chk("hold_dir_lookup", 8'(o_dl), 8'd0);
            if (flush) clear_model(1 - s);
            cyc();
        end
        flush = 1'b0; rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        if (exp_err == 0) lru_m[s][idx] = touch(lru_m[s][idx], exp_way);
        #1;
        chk("retire_rsp_valid", 8'(o_rv), 8'd0);
        chk("retire_req_ready", 8'(o_rr), 8'd1);
    endtask

    task automatic flush_step();
        flush = 1'b1; req_valid = 1'b1; req_idx = 7'd5; #1;
        chk("flush_req_ready", 8'(o_rr), 8'd0);
        cyc();
        flush = 1'b0; req_valid = 1'b0; #1;
        chk("flush_no_lookup", 8'(o_dl), 8'd0);
        chk("flush_ready_after", 8'(o_rr), 8'd1);
        clear_model(0); clear_model(1);
    endtask

    initial begin
        int m_r;
        logic [3:0] m;
        clear_model(0); clear_model(1);
        #2;
        chk("rst_req_ready", 8'(rr1), 8'd1);
        chk("rst_dir_lookup", 8'(dl1), 8'd0);
        chk("rst_dir_idx", 8'(di1), 8'd0);
        chk("rst_rsp_valid", 8'(rv1), 8'd0);
        chk("rst_rsp_hit", 8'(rh1), 8'd0);
        chk("rst_rsp_way", 8'(rw1), 8'd0);
        chk("rst_rsp_err", 8'(re1), 8'd0);
        chk("rst4_rsp_valid", 8'(rv4), 8'd0);
        chk("rst4_req_ready", 8'(rr4), 8'd1);
        #1 rst_n = 1'b1;
        cyc();
        txn(5, 4'b0000, 1'b0, 0, 0);
        txn(5, 4'b0100, 1'b0, 0, 0);
        txn(5, 4'b0000, 1'b0, 0, 0);
        txn(9, 4'b0101, 1'b0, 0, 0);
        txn(9, 4'b0001, 1'b1, 0, 0);
        txn(9, 4'b0000, 1'b0, 0, 0);
        txn(3, 4'b1000, 1'b0, 4, 0);
        txn(5, 4'b0001, 1'b0, 0, 0);
        txn(5, 4'b0100, 1'b0, 0, 0);
        flush_step();
        txn(5, 4'b0000, 1'b0, 0, 0);
        sel = 1'b1;
        txn(5, 4'b0000, 1'b0, 1, 0);
        txn(5, 4'b0000, 1'b0, 0, 2);
        txn(5, 4'b0000, 1'b0, 0, 0);
        sel = 1'b0;
        txn(5, 4'b0000, 1'b0, 0, 0);
        for (int n = 0; n < 50; n++) begin
            sel = (n >= 40);
            if ($urandom_range(0, 7) == 0) flush_step();
            m_r = $urandom_range(0, 9);
            m = (m_r < 4) ? 4'b0000 : (m_r < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            txn($urandom_range(0, 3), m, ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
